// File: rtl/sprite_pkg.sv
// Shared types for the sprite line renderer: object table entry, obj_data field layout, FSM states.
package sprite_pkg;

  localparam int unsigned OBJ_COORD_W = 12;
  localparam int unsigned OBJ_SPR_W   = 6;
  localparam int unsigned OBJ_X_LSB   = 20;
  localparam int unsigned OBJ_Y_LSB   = 8;
  localparam int unsigned OBJ_SPR_LSB = 2;
  localparam int unsigned OBJ_ACT_BIT = 1;

  typedef struct packed {
    logic [OBJ_COORD_W-1:0] x;
    logic [OBJ_COORD_W-1:0] y;
    logic [OBJ_SPR_W-1:0]   sprite;
    logic                   active;
  } obj_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    FETCH,
    DONE
  } state_t;

endpackage

// File: rtl/line_buffer_dp.sv
// Simple dual-port line RAM: one synchronous write port, one registered read port.
module line_buffer_dp #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_line_renderer.sv
// Ping-pong line-buffer sprite renderer: clears and renders the next line from a
// shadowed object table while the other buffer is scanned out.
module sprite_line_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_OBJ   = 20,
  parameter int unsigned SPR_W     = 16,
  parameter int unsigned SPR_H     = 16,
  parameter int unsigned HACTIVE   = 640,
  parameter int unsigned VACTIVE   = 480,
  parameter int unsigned COORD_W   = OBJ_COORD_W,
  parameter int unsigned SPR_IDX_W = OBJ_SPR_W,
  parameter int unsigned PIX_W     = 8,
  localparam int unsigned OBJ_W    = $clog2(NUM_OBJ),
  localparam int unsigned SX_W     = $clog2(SPR_W),
  localparam int unsigned SY_W     = $clog2(SPR_H),
  localparam int unsigned ROM_AW   = SPR_IDX_W + SY_W + SX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              obj_we,
  input  logic [OBJ_W-1:0]  obj_addr,
  input  logic [31:0]       obj_data,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [9:0]        line_y,
  input  logic [9:0]        rd_x,
  output logic [PIX_W-1:0]  rd_pixel,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned AX_W  = $clog2(HACTIVE);
  localparam int unsigned CNT_W = $clog2(SPR_W + 1);
  localparam int unsigned CW1   = COORD_W + 1;

  state_t             state, state_d;
  logic               draw_sel;
  logic [1:0]         disp_ready;
  logic [AX_W-1:0]    clr_addr;
  logic [OBJ_W-1:0]   obj_i;
  logic [SY_W-1:0]    rel_y;
  logic [CNT_W-1:0]   fetch_cnt;
  logic [9:0]         line_q;
  obj_t               live_tbl   [NUM_OBJ];
  obj_t               shadow_tbl [NUM_OBJ];
  obj_t               wr_obj, cur_obj;

  logic               line_ok, hit_c;
  logic [CW1-1:0]     line_e, oy_e, ox_e, col_e;
  logic [SY_W-1:0]    rel_y_hit;
  logic               clr_we, tex_we, buf_we;
  logic [AX_W-1:0]    waddr;
  logic [PIX_W-1:0]   wdata;
  logic [AX_W-1:0]    rd_addr;
  logic               rd_ok_q, rd_sel_q;
  logic [PIX_W-1:0]   rdata0, rdata1;
  logic               unused_obj_bit;

  assign unused_obj_bit = obj_data[0];

  always_comb begin
    wr_obj.x      = obj_data[OBJ_X_LSB +: OBJ_COORD_W];
    wr_obj.y      = obj_data[OBJ_Y_LSB +: OBJ_COORD_W];
    wr_obj.sprite = obj_data[OBJ_SPR_LSB +: OBJ_SPR_W];
    wr_obj.active = obj_data[OBJ_ACT_BIT];
  end

  // Live/shadow tables; a same-cycle write lands after the copy samples the live table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        live_tbl[i]   <= '0;
        shadow_tbl[i] <= '0;
      end
    end else begin
      if (frame_start) shadow_tbl <= live_tbl;
      if (obj_we && (32'(obj_addr) < NUM_OBJ)) live_tbl[obj_addr] <= wr_obj;
    end
  end

  assign cur_obj = shadow_tbl[obj_i];

  // Hit test and column math in COORD_W+1 bits so nothing wraps.
  always_comb begin
    line_ok   = 32'(line_q) < VACTIVE;
    line_e    = CW1'(line_q);
    oy_e      = CW1'(cur_obj.y);
    ox_e      = CW1'(cur_obj.x);
    hit_c     = cur_obj.active && line_ok && (line_e >= oy_e) &&
                (line_e < oy_e + CW1'(SPR_H));
    rel_y_hit = SY_W'(line_e - oy_e);
    col_e     = ox_e + CW1'(fetch_cnt) - CW1'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    clr_we  = 1'b0;
    tex_we  = 1'b0;
    unique case (state)
      IDLE: ;
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_addr == AX_W'(HACTIVE - 1)) state_d = SCAN;
      end
      SCAN: begin
        if (hit_c)             state_d = FETCH;
        else if (obj_i == '0)  state_d = DONE;
      end
      FETCH: begin
        tex_we = (fetch_cnt != '0) && (rom_data != '0) && (col_e < CW1'(HACTIVE));
        if (fetch_cnt == CNT_W'(SPR_W)) state_d = (obj_i == '0) ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (line_start) state_d = CLEAR;
    buf_we = clr_we | tex_we;
    waddr  = clr_we ? clr_addr : AX_W'(col_e);
    wdata  = clr_we ? '0 : rom_data;
  end

  // Render datapath; line_start overrides whatever the FSM was doing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_sel   <= 1'b0;
      disp_ready <= 2'b00;
      clr_addr   <= '0;
      obj_i      <= '0;
      rel_y      <= '0;
      fetch_cnt  <= '0;
      line_q     <= '0;
      rom_addr   <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (line_start) begin
        draw_sel              <= ~draw_sel;
        disp_ready[!draw_sel] <= 1'b0;
        clr_addr              <= '0;
        line_q                <= line_y;
        if (state != IDLE) overrun <= 1'b1;
      end else begin
        unique case (state)
          CLEAR: begin
            clr_addr <= clr_addr + AX_W'(1);
            if (state_d == SCAN) obj_i <= OBJ_W'(NUM_OBJ - 1);
          end
          SCAN: begin
            if (hit_c) begin
              rel_y     <= rel_y_hit;
              fetch_cnt <= '0;
              rom_addr  <= {SPR_IDX_W'(cur_obj.sprite), rel_y_hit, SX_W'(0)};
            end else if (obj_i != '0) begin
              obj_i <= obj_i - OBJ_W'(1);
            end
          end
          FETCH: begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (fetch_cnt < CNT_W'(SPR_W - 1))
              rom_addr <= {SPR_IDX_W'(cur_obj.sprite), rel_y, SX_W'(fetch_cnt + CNT_W'(1))};
            if ((fetch_cnt == CNT_W'(SPR_W)) && (obj_i != '0)) obj_i <= obj_i - OBJ_W'(1);
          end
          DONE:    disp_ready[draw_sel] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  line_buffer_dp #(.DEPTH(HACTIVE), .WIDTH(PIX_W)) u_buf0 (
    .clk   (clk),
    .we    (buf_we && !draw_sel),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  line_buffer_dp #(.DEPTH(HACTIVE), .WIDTH(PIX_W)) u_buf1 (
    .clk   (clk),
    .we    (buf_we && draw_sel),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  // Scan-out: gate flags are registered alongside the RAM read.
  assign rd_addr = (32'(rd_x) < HACTIVE) ? AX_W'(rd_x) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ok_q  <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      rd_ok_q  <= (32'(rd_x) < HACTIVE) && disp_ready[!draw_sel];
      rd_sel_q <= !draw_sel;
    end
  end

  assign rd_pixel = !rd_ok_q ? '0 : (rd_sel_q ? rdata1 : rdata0);

endmodule
